mic_array_ctrl: RTL and testbench

MIC_ARRAY_CTRL -- requirements
Module: mic_array_ctrl

---
 rtl/mic_array_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mic_array_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_array_ctrl.sv
// rtl/mic_array_ctrl.sv - I2S master clocks for two stereo receivers plus a frame aligner with a one-deep output buffer.
// Define MIC_ARRAY_CTRL_FRAME_CNT_EN to build the completed-transfer counter behind frame_cnt.
module mic_array_ctrl #(
    parameter int DATA_WIDTH    = 24,
    parameter int CLK_DIV       = 4,
    parameter int SLOT_BITS     = 32,
    parameter int ALIGN_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    bclk,
    output logic                    ws,
    input  logic [DATA_WIDTH-1:0]   rx0_left,
    input  logic [DATA_WIDTH-1:0]   rx0_right,
    input  logic [DATA_WIDTH-1:0]   rx1_left,
    input  logic [DATA_WIDTH-1:0]   rx1_right,
    input  logic                    rx0_valid,
    input  logic                    rx1_valid,
    output logic [4*DATA_WIDTH-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [15:0]             frame_cnt,
    output logic                    overflow,
    output logic                    align_err,
    input  logic                    clr_err
);

    localparam int DIVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BITW = $clog2(2 * SLOT_BITS);
    localparam int TOW  = $clog2(ALIGN_TIMEOUT + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(2 * SLOT_BITS - 1);
    localparam logic [BITW-1:0] SLOT_LIM = BITW'(SLOT_BITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} clk_state_t;
    typedef enum logic [1:0] {A_WAIT, A_HAVE0, A_HAVE1} al_state_t;

    clk_state_t      c_state;
    logic [DIVW-1:0] div;
    logic [BITW-1:0] bit_cnt;
    logic [BITW-1:0] bit_next;

    assign bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BITW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state <= IDLE;
            bclk    <= 1'b0;
            ws      <= 1'b1;
            div     <= '0;
            bit_cnt <= BIT_LAST;
        end else begin
            case (c_state)
                IDLE: begin
                    bclk    <= 1'b0;
                    ws      <= 1'b1;
                    div     <= '0;
                    bit_cnt <= BIT_LAST;
                    if (enable) c_state <= RUN;
                end
                default: begin
                    c_state <= enable ? RUN : DRAIN;
                    if (div == DIV_LAST) begin
                        div  <= '0;
                        bclk <= ~bclk;
                        if (bclk) begin
                            // Falling edge: the frame-ending edge of a drain parks the clocks.
                            if (c_state == DRAIN && !enable && bit_next == '0) begin
                                c_state <= IDLE;
                                ws      <= 1'b1;
                                bit_cnt <= BIT_LAST;
                            end else begin
                                bit_cnt <= bit_next;
                                ws      <= (bit_next >= SLOT_LIM);
                            end
                        end
                    end else begin
                        div <= div + DIVW'(1);
                    end
                end
            endcase
        end
    end

    al_state_t               a_state;
    logic [DATA_WIDTH-1:0]   hold_left;
    logic [DATA_WIDTH-1:0]   hold_right;
    logic [TOW-1:0]          tmo;
    logic                    asm_fire;
    logic                    align_set;
    logic [4*DATA_WIDTH-1:0] asm_data;
    logic                    xfer;

    assign xfer = frame_valid & frame_ready;

    always_comb begin
        asm_fire  = 1'b0;
        align_set = 1'b0;
        asm_data  = '0;
        case (a_state)
            A_WAIT: begin
                if (rx0_valid && rx1_valid) begin
                    asm_fire = 1'b1;
                    asm_data = {rx1_right, rx1_left, rx0_right, rx0_left};
                end
            end
            A_HAVE0: begin
                if (rx1_valid) begin
                    asm_fire = 1'b1;
                    asm_data = {rx1_right, rx1_left, hold_right, hold_left};
                end else if (rx0_valid || tmo <= TOW'(1)) begin
                    align_set = 1'b1;
                end
            end
            default: begin
                if (rx0_valid) begin
                    asm_fire = 1'b1;
                    asm_data = {hold_right, hold_left, rx0_right, rx0_left};
                end else if (rx1_valid || tmo <= TOW'(1)) begin
                    align_set = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state    <= A_WAIT;
            hold_left  <= '0;
            hold_right <= '0;
            tmo        <= '0;
        end else begin
            case (a_state)
                A_WAIT: begin
                    if (rx0_valid && !rx1_valid) begin
                        a_state    <= A_HAVE0;
                        hold_left  <= rx0_left;
                        hold_right <= rx0_right;
                        tmo        <= TOW'(ALIGN_TIMEOUT);
                    end else if (rx1_valid && !rx0_valid) begin
                        a_state    <= A_HAVE1;
                        hold_left  <= rx1_left;
                        hold_right <= rx1_right;
                        tmo        <= TOW'(ALIGN_TIMEOUT);
                    end
                end
                A_HAVE0: begin
                    if (rx1_valid) begin
                        a_state <= A_WAIT;
                    end else if (rx0_valid) begin
                        hold_left  <= rx0_left;
                        hold_right <= rx0_right;
                        tmo        <= TOW'(ALIGN_TIMEOUT);
                    end else if (tmo <= TOW'(1)) begin
                        a_state <= A_WAIT;
                    end else begin
                        tmo <= tmo - TOW'(1);
                    end
                end
                default: begin
                    if (rx0_valid) begin
                        a_state <= A_WAIT;
                    end else if (rx1_valid) begin
                        hold_left  <= rx1_left;
                        hold_right <= rx1_right;
                        tmo        <= TOW'(ALIGN_TIMEOUT);
                    end else if (tmo <= TOW'(1)) begin
                        a_state <= A_WAIT;
                    end else begin
                        tmo <= tmo - TOW'(1);
                    end
                end
            endcase
        end
    end

    // One-deep holding register: a new frame may replace only an empty or departing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            if (asm_fire && (!frame_valid || xfer)) begin
                frame_data  <= asm_data;
                frame_valid <= 1'b1;
            end else if (xfer) begin
                frame_valid <= 1'b0;
            end
            if (asm_fire && frame_valid && !frame_ready) overflow <= 1'b1;
            else if (clr_err)                            overflow <= 1'b0;
            if (align_set)    align_err <= 1'b1;
            else if (clr_err) align_err <= 1'b0;
        end
    end

`ifdef MIC_ARRAY_CTRL_FRAME_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt_q <= '0;
        else if (xfer) cnt_q <= cnt_q + 16'd1;
    end
    assign frame_cnt = cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mic_array_ctrl.sv
// tb/tb_mic_array_ctrl.sv - scoreboard bench for mic_array_ctrl with a transaction-level aligner/buffer model.
module tb_mic_array_ctrl;
    localparam int DW = 24;
    localparam int CD = 2;
    localparam int SB = 32;
    localparam int TO = 64;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic bclk, ws;
    logic [DW-1:0] r0l = '0, r0r = '0, r1l = '0, r1r = '0;
    logic v0 = 1'b0, v1 = 1'b0, frame_ready = 1'b1, clr_err = 1'b0;
    logic [4*DW-1:0] frame_data;
    logic frame_valid, overflow, align_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    mic_array_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD), .SLOT_BITS(SB), .ALIGN_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bclk(bclk), .ws(ws),
        .rx0_left(r0l), .rx0_right(r0r), .rx1_left(r1l), .rx1_right(r1r),
        .rx0_valid(v0), .rx1_valid(v1),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_cnt(frame_cnt), .overflow(overflow), .align_err(align_err), .clr_err(clr_err));

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending half-frame with arrival time, one-slot output buffer, sticky flags.
    logic [4*DW-1:0] exp_q[$];
    bit m_full = 0, m_aerr = 0, m_ovf = 0;
    int pend = -1, pend_t = 0, mcyc = 0;
    logic [DW-1:0] pend_l, pend_r;
    logic [15:0] m_cnt = '0;

    task automatic model_step(input bit a0, input bit a1, input logic [DW-1:0] l0, input logic [DW-1:0] q0,
                              input logic [DW-1:0] l1, input logic [DW-1:0] q1, input bit rdy, input bit clr);
        bit got = 0, aset = 0, oset = 0, xfer;
        logic [4*DW-1:0] f = '0;
        xfer = m_full && rdy;
        if (pend < 0) begin
            if (a0 && a1) begin got = 1; f = {q1, l1, q0, l0}; end
            else if (a0) begin pend = 0; pend_l = l0; pend_r = q0; pend_t = mcyc; end
            else if (a1) begin pend = 1; pend_l = l1; pend_r = q1; pend_t = mcyc; end
        end else if (pend == 0) begin
            if (a1) begin got = 1; f = {q1, l1, pend_r, pend_l}; pend = -1; end
            else if (a0) begin pend_l = l0; pend_r = q0; pend_t = mcyc; aset = 1; end
        end else begin
            if (a0) begin got = 1; f = {pend_r, pend_l, q0, l0}; pend = -1; end
            else if (a1) begin pend_l = l1; pend_r = q1; pend_t = mcyc; aset = 1; end
        end
        if (pend >= 0 && mcyc - pend_t >= TO) begin pend = -1; aset = 1; end
        if (got) begin
            if (!m_full || xfer) begin exp_q.push_back(f); m_full = 1; end
            else oset = 1;
        end else if (xfer) m_full = 0;
`ifdef MIC_ARRAY_CTRL_FRAME_CNT_EN
        if (xfer) m_cnt = m_cnt + 16'd1;
`endif
        m_aerr = aset ? 1'b1 : (clr ? 1'b0 : m_aerr);
        m_ovf  = oset ? 1'b1 : (clr ? 1'b0 : m_ovf);
        mcyc++;
    endtask

    task automatic cyc(input bit a0, input bit a1, input logic [DW-1:0] l0, input logic [DW-1:0] q0,
                       input logic [DW-1:0] l1, input logic [DW-1:0] q1, input bit rdy, input bit clr);
        v0 = a0; v1 = a1; r0l = l0; r0r = q0; r1l = l1; r1r = q1; frame_ready = rdy; clr_err = clr;
        model_step(a0, a1, l0, q0, l1, q1, rdy, clr);
        @(posedge clk); #1;
        v0 = 0; v1 = 0; clr_err = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cyc(0, 0, '0, '0, '0, '0, rdy, 0);
    endtask

    task automatic pair(input logic [DW-1:0] base, input bit rdy);
        cyc(1, 1, base, base + 1, base + 2, base + 3, rdy, 0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_align_err"}, align_err, m_aerr);
        check({tag, "_overflow"}, overflow, m_ovf);
        check({tag, "_frame_valid"}, frame_valid, m_full);
        check({tag, "_frame_cnt"}, frame_cnt, m_cnt);
    endtask

    logic [4*DW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_frame: got %0h expected none", frame_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame_data", frame_data, mon_exp);
            end
        end
    end

    int ccyc = 0;
    logic pb = 1'b0, pw = 1'b1;
    int fall_q[$], wsf_q[$], wsr_q[$];
    always @(posedge clk) ccyc++;
    always @(negedge clk) begin
        if (pb && !bclk) fall_q.push_back(ccyc);
        if (pw && !ws)   wsf_q.push_back(ccyc);
        if (!pw && ws)   wsr_q.push_back(ccyc);
        pb = bclk; pw = ws;
    end

    task automatic wait_falls(input int n);
        int target = fall_q.size() + n;
        int t = 0;
        while (fall_q.size() < target && t < 2000) begin idle(1, 1); t++; end
        check("wait_bclk_fall", fall_q.size() >= target, 1);
    endtask

    task automatic wait_ws_fall();
        int target = wsf_q.size() + 1;
        int t = 0;
        while (wsf_q.size() < target && t < 2000) begin idle(1, 1); t++; end
        check("wait_ws_fall", wsf_q.size() >= target, 1);
    endtask

    initial begin
        int bad, k0, nf, nw;
        logic [DW-1:0] a, b, c, d;
        bit a0, a1, rdy, clr;
        int r;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bclk", bclk, 0);
        check("rst_ws", ws, 1);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_align_err", align_err, 0);
        rst_n = 1;

        // Clock generation from IDLE
        fall_q.delete(); wsf_q.delete(); wsr_q.delete();
        enable = 1;
        idle(2 * 2 * SB * 2 * CD + 40, 1);
        bad = 0;
        for (int i = 1; i < fall_q.size(); i++) if (fall_q[i] - fall_q[i-1] != 2 * CD) bad++;
        check("bclk_period", bad, 0);
        check("ws_fall_at_first_bclk_fall", wsf_q[0], fall_q[0]);
        check("ws_low_len", wsr_q[0] - wsf_q[0], SB * 2 * CD);
        check("frame_len", wsf_q[1] - wsf_q[0], 2 * SB * 2 * CD);

        // Disable at bit 10: drain to frame end, then park
        wait_ws_fall();
        wait_falls(10);
        enable = 0;
        k0 = fall_q.size(); nw = wsf_q.size();
        idle(400, 1);
        check("drain_falls", fall_q.size() - k0, 2 * SB - 10);
        check("park_bclk", bclk, 0);
        check("park_ws", ws, 1);
        check("park_no_ws_fall", wsf_q.size(), nw);
        nf = fall_q.size();
        idle(50, 1);
        check("park_quiet", fall_q.size(), nf);

        // Re-enable during drain: bclk must keep its cadence
        enable = 1;
        wait_ws_fall();
        wait_falls(10);
        enable = 0;
        k0 = fall_q.size();
        wait_falls(5);
        enable = 1;
        idle(300, 1);
        bad = 0;
        for (int i = k0; i < fall_q.size(); i++) if (fall_q[i] - fall_q[i-1] != 2 * CD) bad++;
        check("reenable_no_gap", bad, 0);
        check("reenable_kept_running", (fall_q.size() - k0) > (2 * SB - 10), 1);
        enable = 0;
        idle(600, 1);

        // Simultaneous pair
        cyc(1, 1, 24'h000001, 24'h000002, 24'h000003, 24'h000004, 1, 0);
        check("pair_valid", frame_valid, 1);
        check("pair_data", frame_data, 96'h000004_000003_000002_000001);
        idle(2, 1);
        check_model("pair");

        // Gap exactly at the timeout boundary is accepted
        cyc(1, 0, 24'h10, 24'h11, '0, '0, 1, 0);
        idle(TO - 1, 1);
        cyc(0, 1, '0, '0, 24'h12, 24'h13, 1, 0);
        idle(3, 1);
        check_model("gap64");

        // Gap of 70 times out
        cyc(1, 0, 24'h20, 24'h21, '0, '0, 1, 0);
        idle(69, 1);
        cyc(0, 1, '0, '0, 24'h22, 24'h23, 1, 0);
        idle(TO + 6, 1);
        check("gap70_align_err", align_err, 1);
        check_model("gap70");
        pair(24'h30, 1);
        idle(2, 1);
        cyc(0, 0, '0, '0, '0, '0, 1, 1);
        check_model("clr_align");

        // Repeat valid together with clr: the set wins
        cyc(1, 0, 24'h40, 24'h41, '0, '0, 1, 0);
        cyc(1, 0, 24'h42, 24'h43, '0, '0, 1, 1);
        check("repeat_set_wins", align_err, 1);
        cyc(0, 1, '0, '0, 24'h44, 24'h45, 1, 1);
        idle(2, 1);
        check_model("repeat");

        // Backpressure across two assemblies
        pair(24'h50, 0);
        idle(3, 0);
        pair(24'h60, 0);
        idle(2, 0);
        check("ovf_set", overflow, 1);
        check("ovf_held_data", frame_data, {24'h53, 24'h52, 24'h51, 24'h50});
        cyc(0, 0, '0, '0, '0, '0, 0, 1);
        check("ovf_cleared", overflow, 0);
        idle(3, 1);

        // Assembly in the same cycle as a completed transfer
        pair(24'h70, 0);
        idle(1, 0);
        pair(24'h80, 1);
        idle(1, 0);
        check("swap_no_ovf", overflow, 0);
        check("swap_data", frame_data, {24'h83, 24'h82, 24'h81, 24'h80});
        idle(3, 1);
        check_model("swap");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            a0 = 0; a1 = 0;
            if (r == 99) begin idle(TO + 5, 1); continue; end
            if (r < 8) begin
                if (pend < 0) begin a0 = 1; a1 = 1; end
                else if (pend == 0) a1 = 1;
                else a0 = 1;
            end else if (r < 16) a0 = 1;
            else if (r < 24) a1 = 1;
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 49) == 0);
            a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
            cyc(a0, a1, a, b, c, d, rdy, clr);
            if (i % 100 == 99) check_model("rand");
        end
        idle(TO + 5, 1);
        check_model("rand_end");

        // Reset mid-frame with a held frame and a pending half
        enable = 1;
        idle(40, 1);
        pair(24'h90, 0);
        cyc(1, 0, 24'h95, 24'h96, '0, '0, 0, 0);
        idle(2, 0);
        #2 rst_n = 0;
        #1;
        check("rst2_frame_valid", frame_valid, 0);
        check("rst2_frame_data", frame_data, 0);
        check("rst2_bclk", bclk, 0);
        check("rst2_ws", ws, 1);
        check("rst2_overflow", overflow, 0);
        check("rst2_align_err", align_err, 0);
        check("rst2_frame_cnt", frame_cnt, 0);
        exp_q.delete(); m_full = 0; pend = -1; m_aerr = 0; m_ovf = 0; m_cnt = '0;
        enable = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Three completed transfers
        for (int i = 0; i < 3; i++) begin pair(DW'(24'hA0 + 16 * i), 1); idle(1, 1); end
        idle(TO + 5, 1);
`ifdef MIC_ARRAY_CTRL_FRAME_CNT_EN
        check("frame_cnt_3", frame_cnt, 16'd3);
`else
        check("frame_cnt_3", frame_cnt, 16'd0);
`endif
        check("post_rst_align_err", align_err, 0);
        check_model("final");
        idle(5, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
